nod8: RTL and testbench

NOD8 -- requirements
Module: nod8

---
 rtl/nod8.sv | 73 +++++++
 tb/tb_nod8.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/nod8.sv
// Nearest-power-of-two encoder: one registered result per accepted 8-bit operand.
// Optional build macro NOD8_TIE_DOWN_EN makes exact midpoints round down instead of up.
module nod8 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       valid_i,
  input  logic [7:0] data_i,
  output logic       valid_o,
  output logic       zero_o,
  output logic [8:0] data_o,
  output logic [3:0] exp_o
);

  localparam int unsigned DW = 8;
  localparam int unsigned RW = 9;
  localparam int unsigned EW = 4;
  localparam int unsigned KW = 3;

  logic [KW-1:0] msb_c;
  logic          half_c;
  logic          sticky_c;
  logic          nonzero_c;
  logic          round_up_c;
  logic [EW-1:0] exp_c;
  logic [RW-1:0] data_c;

  // Leading-one position plus the bit just below it (half) and everything under that (sticky)
  always_comb begin
    msb_c    = '0;
    half_c   = 1'b0;
    sticky_c = 1'b0;
    for (int i = 0; i < int'(DW); i++) begin
      if (data_i[i]) msb_c = KW'(i);
    end
    for (int i = 0; i < int'(DW) - 1; i++) begin
      if (i + 1 == int'(msb_c)) begin
        half_c = data_i[i];
      end else if (i + 1 < int'(msb_c)) begin
        sticky_c = sticky_c | data_i[i];
      end
    end
  end

  assign nonzero_c = |data_i;

`ifdef NOD8_TIE_DOWN_EN
  // A midpoint has only the half bit set below the leading one; it stays at 2^k
  assign round_up_c = half_c & sticky_c;
`else
  assign round_up_c = half_c;
`endif

  assign exp_c  = EW'(msb_c) + EW'(round_up_c);
  assign data_c = RW'(1) << exp_c;

  // Result registers; results hold while no operand is offered
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_o <= 1'b0;
      zero_o  <= 1'b1;
      data_o  <= '0;
      exp_o   <= '0;
    end else begin
      valid_o <= valid_i;
      if (valid_i) begin
        zero_o <= ~nonzero_c;
        data_o <= nonzero_c ? data_c : '0;
        exp_o  <= nonzero_c ? exp_c : '0;
      end
    end
  end

endmodule

// File: tb/tb_nod8.sv
// Self-checking bench for nod8: directed cases, async reset, exhaustive sweep and random traffic
// against a distance-based nearest-power-of-two model.
module tb_nod8;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       valid_i;
  logic [7:0] data_i;
  logic       valid_o;
  logic       zero_o;
  logic [8:0] data_o;
  logic [3:0] exp_o;

  int n_chk  = 0;
  int n_pass = 0;

  // Expected output state
  logic       m_valid;
  logic       m_zero;
  logic [8:0] m_data;
  logic [3:0] m_exp;

  nod8 dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (valid_i),
    .data_i  (data_i),
    .valid_o (valid_o),
    .zero_o  (zero_o),
    .data_o  (data_o),
    .exp_o   (exp_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input int got, input int want);
    n_chk++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, want);
  endtask

  // Nearest power of two by comparing distances to the bracketing powers
  task automatic ref_model(input int x, output logic z, output logic [8:0] d, output logic [3:0] e);
    int p, k, dlo, dhi;
    bit up;
    if (x == 0) begin
      z = 1'b1; d = '0; e = '0;
    end else begin
      p = 1; k = 0;
      while (p * 2 <= x) begin
        p = p * 2;
        k++;
      end
      dlo = x - p;
      dhi = 2 * p - x;
`ifdef NOD8_TIE_DOWN_EN
      up = (dhi < dlo);
`else
      up = (dhi <= dlo);
`endif
      z = 1'b0;
      d = up ? 9'(2 * p) : 9'(p);
      e = up ? 4'(k + 1) : 4'(k);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_valid"}, int'(valid_o), int'(m_valid));
    check({tag, "_zero"},  int'(zero_o),  int'(m_zero));
    check({tag, "_data"},  int'(data_o),  int'(m_data));
    check({tag, "_exp"},   int'(exp_o),   int'(m_exp));
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_zero = 1'b1; m_data = '0; m_exp = '0;
  endtask

  // One clock: drive, advance past the edge, update model, compare
  task automatic cycle(input logic v, input logic [7:0] d, input string tag);
    valid_i = v;
    data_i  = d;
    @(posedge clk_i);
    #1;
    m_valid = v;
    if (v) ref_model(int'(d), m_zero, m_data, m_exp);
    check_outputs(tag);
  endtask

  initial begin
    logic [7:0] v8;
    logic [8:0] mid3, mid192;
    rst_i   = 1'b1;
    valid_i = 1'b0;
    data_i  = '0;
    model_reset();
    #2;
    check_outputs("reset0");
    @(posedge clk_i);
    #1;
    check_outputs("reset_edge");
    rst_i = 1'b0;

    // Directed values against hand-derived constants
    cycle(1'b1, 8'd204, "v204");
    check("c204_data", int'(data_o), 256);
    check("c204_exp", int'(exp_o), 8);
    cycle(1'b1, 8'd170, "v170");
    check("c170_data", int'(data_o), 128);
    check("c170_exp", int'(exp_o), 7);
    cycle(1'b1, 8'd0, "v0");
    check("c0_zero", int'(zero_o), 1);
    cycle(1'b1, 8'd1, "v1");
    check("c1_data", int'(data_o), 1);
    cycle(1'b1, 8'd255, "v255");
    check("c255_data", int'(data_o), 256);

`ifdef NOD8_TIE_DOWN_EN
    mid3 = 9'd2;   mid192 = 9'd128;
`else
    mid3 = 9'd4;   mid192 = 9'd256;
`endif
    cycle(1'b1, 8'd3, "v3");
    check("c3_data", int'(data_o), int'(mid3));
    cycle(1'b1, 8'd192, "v192");
    check("c192_data", int'(data_o), int'(mid192));

    // Back-to-back stream then idle hold
    cycle(1'b1, 8'd5, "b5");
    check("cb5", int'(data_o), 4);
    cycle(1'b1, 8'd6, "b6");
    check("cb6", int'(data_o), 8);
    cycle(1'b1, 8'd12, "b12");
    check("cb12", int'(data_o), 16);
    cycle(1'b1, 8'd96, "b96");
    check("cb96", int'(data_o), 128);
    cycle(1'b0, 8'd77, "idle");
    check("cidle_data", int'(data_o), 128);
    check("cidle_valid", int'(valid_o), 0);

    // Asynchronous reset between edges; operand on a reset edge is dropped
    cycle(1'b1, 8'd100, "pre_rst");
    #2;
    rst_i = 1'b1;
    #1;
    model_reset();
    check_outputs("async_rst");
    valid_i = 1'b1;
    data_i  = 8'd50;
    @(posedge clk_i);
    #1;
    check_outputs("rst_hold");
    #2;
    rst_i = 1'b0;
    #1;
    check_outputs("rst_release");
    cycle(1'b1, 8'd40, "post_rst");
    check("cpost_data", int'(data_o), 32);

    // Exhaustive sweep
    for (int i = 0; i < 256; i++) begin
      v8 = 8'(i);
      cycle(1'b1, v8, "sweep");
    end

    // Random traffic with gaps
    for (int i = 0; i < 300; i++) begin
      v8 = 8'($urandom_range(0, 255));
      cycle(1'($urandom_range(0, 3) != 0), v8, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
